// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared types and constants for the instruction-fetch sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch sequencer states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  // Size of one instruction word in bytes (sequential PC step)
  localparam logic [31:0] INST_BYTES = 32'd4;

  // Reset PC used when the top is not overridden
  localparam logic [31:0] DEFAULT_START_ADDR = 32'h8000_0000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_ctrl_next_pc_sel.sv
`default_nettype none
// ============================================================================
//  Module   : next_pc_sel
//  Brief    : Next-PC priority decode applied when decode accepts the held
//             instruction: halt > misaligned redirect > redirect > sequential.
//  Revision : 1.0 - initial release
// ============================================================================
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] next_pc,
  output state_t      next_state,
  output logic        misalign_fault
);

  logic w_misalign;

  assign w_misalign = (redirect_pc[1:0] != 2'b00);

  // Resolve the accepted instruction's successor; halt wins over any redirect
  always_comb begin
    next_pc        = pc + INST_BYTES;
    next_state     = ST_REQ;
    misalign_fault = 1'b0;
    if (halt) begin
      next_pc    = pc;
      next_state = ST_HALT;
    end else if (redirect_valid && w_misalign && CHECK_ALIGN) begin
      next_pc        = pc;
      next_state     = ST_FAULT;
      misalign_fault = 1'b1;
    end else if (redirect_valid) begin
      // With alignment checking off, the low bits of the target are dropped
      next_pc    = CHECK_ALIGN ? redirect_pc : {redirect_pc[31:2], 2'b00};
      next_state = ST_REQ;
    end
  end

endmodule : next_pc_sel
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl
//  Brief    : Multi-cycle RV32 instruction-fetch sequencer. Owns the PC,
//             issues one fetch per instruction, holds the fetched word for
//             decode and applies sequential/redirect/halt/fault next-PC.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] START_ADDR  = DEFAULT_START_ADDR,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] instret
);

  state_t      r_state;
  state_t      w_state_next;
  state_t      w_sel_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_fault_pc;
  logic [31:0] r_instret;
  logic [31:0] w_next_pc;
  logic        w_misalign_fault;

  next_pc_sel #(
    .CHECK_ALIGN (CHECK_ALIGN)
  ) u_next_pc_sel (
    .pc             (r_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .next_pc        (w_next_pc),
    .next_state     (w_sel_state),
    .misalign_fault (w_misalign_fault)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_REQ;
    else      r_state <= w_state_next;
  end

  // Next-state decode; responses outside WAIT and redirects outside ISSUE are ignored
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_REQ:   if (imem_req_ready) w_state_next = ST_WAIT;
      ST_WAIT:  if (imem_rsp_valid) w_state_next = imem_rsp_err ? ST_FAULT : ST_ISSUE;
      ST_ISSUE: if (inst_ready)     w_state_next = w_sel_state;
      ST_HALT:  w_state_next = ST_HALT;
      ST_FAULT: w_state_next = ST_FAULT;
      default:  w_state_next = ST_FAULT;
    endcase
  end

  // PC, held instruction, fault address and retire counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc       <= START_ADDR;
      r_inst     <= 32'd0;
      r_fault_pc <= 32'd0;
      r_instret  <= 32'd0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (imem_rsp_err) r_fault_pc <= r_pc;
            else              r_inst     <= imem_rsp_data;
          end
        end
        ST_ISSUE: begin
          if (inst_ready) begin
            // The branch itself completes even when its target faults
            r_instret <= r_instret + 32'd1;
            r_pc      <= w_next_pc;
            if (w_misalign_fault) r_fault_pc <= redirect_pc;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state; held low while reset is asserted
  assign imem_req_valid = rst && (r_state == ST_REQ);
  assign imem_req_addr  = r_pc;
  assign inst_valid     = rst && (r_state == ST_ISSUE);
  assign inst           = r_inst;
  assign inst_pc        = r_pc;
  assign halted         = rst && (r_state == ST_HALT);
  assign fault          = rst && (r_state == ST_FAULT);
  assign fault_pc       = r_fault_pc;
  assign instret        = r_instret;

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_ctrl
//  Brief    : Self-checking bench for fetch_ctrl with address/instruction
//             scoreboards driven by a small next-PC model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam logic [31:0] C_START = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] instret;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_inst_q[$];

  always #5 clk = ~clk;

  fetch_ctrl #(
    .START_ADDR  (C_START),
    .CHECK_ALIGN (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .instret        (instret)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for two cycles, checking outputs while reset is held
  task automatic do_reset();
    rst = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    imem_rsp_err = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; halt = 1'b0;
    tick(); tick();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    exp_addr_q.delete();
    exp_inst_q.delete();
    exp_addr_q.push_back(C_START);
    rst = 1'b1;
  endtask

  // Handshake one request, then answer it in the following cycle
  task automatic fetch_one(input logic [31:0] data, input logic err);
    logic [31:0] a;
    int          waited = 0;
    while (!imem_req_valid && waited < 20) begin
      tick();
      waited++;
    end
    if (!imem_req_valid) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    a = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hxxxx_xxxx;
    chk("req_addr", imem_req_addr, a);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = data; imem_rsp_err = err;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    if (!err) exp_inst_q.push_back({a, data});
  endtask

  // Accept the held instruction and predict the next fetch address
  task automatic accept(input logic rv, input logic [31:0] rpc, input logic hl);
    logic [63:0] e;
    e = (exp_inst_q.size() != 0) ? exp_inst_q.pop_front() : 64'hxxxx_xxxx_xxxx_xxxx;
    chk("inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("inst", inst, e[31:0]);
    chk("inst_pc", inst_pc, e[63:32]);
    inst_ready = 1'b1; redirect_valid = rv; redirect_pc = rpc; halt = hl;
    tick();
    inst_ready = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
    if (!hl) begin
      if (rv && rpc[1:0] == 2'b00) exp_addr_q.push_back(rpc);
      else if (!rv)                exp_addr_q.push_back(e[63:32] + 32'd4);
    end
  endtask

  initial begin
    logic [31:0] s_inst, s_pc, s_ret;

    // Sequential stream of NOPs
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fetch_one(32'h0000_0013, 1'b0);
      accept(1'b0, 32'd0, 1'b0);
    end
    chk("instret_3", instret, 32'd3);

    // Stall in ISSUE, then redirect, then misaligned redirect
    fetch_one(32'h1234_5678, 1'b0);
    s_inst = inst; s_pc = inst_pc; s_ret = instret;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_inst", inst, s_inst);
      chk("stall_pc", inst_pc, s_pc);
      chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("stall_instret", instret, s_ret);
    end
    accept(1'b1, 32'h8000_0100, 1'b0);
    fetch_one(32'h0000_006f, 1'b0);
    accept(1'b1, 32'h8000_0102, 1'b0);
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h8000_0102);
    chk("mis_instret", instret, 32'd5);
    tick(); tick();
    chk("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
    chk("mis_sticky", {31'd0, fault}, 32'd1);

    // Access error on the second fetch
    do_reset();
    fetch_one(32'h0000_0013, 1'b0);
    accept(1'b0, 32'd0, 1'b0);
    fetch_one(32'hDEAD_BEEF, 1'b1);
    chk("err_fault", {31'd0, fault}, 32'd1);
    chk("err_fault_pc", fault_pc, 32'h8000_0004);
    tick();
    chk("err_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("err_no_req", {31'd0, imem_req_valid}, 32'd0);

    // Halt beats a simultaneous redirect
    do_reset();
    fetch_one(32'h0010_0073, 1'b0);
    accept(1'b1, 32'h8000_0200, 1'b1);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
    chk("halt_no_fault", {31'd0, fault}, 32'd0);
    tick();
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    chk("halt_inst_valid", {31'd0, inst_valid}, 32'd0);

    // Reset mid-WAIT with a stale response right after release
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b0;
    tick();
    chk("wrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_F00D;
    tick();
    imem_rsp_valid = 1'b0;
    chk("stale_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("stale_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("stale_inst", inst, 32'd0);

    // Address wrap at the top of the space
    fetch_one(32'h0000_0013, 1'b0);
    accept(1'b1, 32'hFFFF_FFFC, 1'b0);
    fetch_one(32'h0000_0013, 1'b0);
    accept(1'b0, 32'd0, 1'b0);
    fetch_one(32'h0000_0013, 1'b0);
    chk("wrap_inst_pc", inst_pc, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_fetch_ctrl
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Multi-cycle instruction-fetch sequencer for the single-issue RV32 core.
- Owns the architectural PC and issues one word fetch per instruction over a valid/ready instruction-memory port.
- Holds the fetched word until the decode/execute side accepts it, then applies the next-PC decision: sequential, redirect, halt or fault.
- Sits between instruction memory and the decoder, and replaces a free-running PC register.

Parameters:
- START_ADDR, 32'h80000000, PC value loaded on reset.
- CHECK_ALIGN, 1, when 1 a redirect target with bits [1:0] != 0 raises a fault; when 0, bits [1:0] are forced to 0.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address (= pc).
- imem_rsp_valid  in  1  fetch response valid (single-cycle pulse, no backpressure).
- imem_rsp_data  in  32  fetched instruction word.
- imem_rsp_err  in  1  access error, qualified by imem_rsp_valid.
- inst_valid  out  1  instruction available to decode.
- inst  out  32  held instruction word.
- inst_pc  out  32  PC of the held instruction.
- inst_ready  in  1  decode/execute completes the held instruction this cycle.
- redirect_valid  in  1  taken branch/jump, qualified by inst_valid & inst_ready.
- redirect_pc  in  32  redirect target.
- halt  in  1  held instruction is ebreak, qualified by inst_valid & inst_ready.
- halted  out  1  sticky halt indication.
- fault  out  1  sticky fetch/alignment fault.
- fault_pc  out  32  faulting address.
- instret  out  32  count of completed instructions.

Behaviour:
- States: REQ, WAIT, ISSUE, HALT, FAULT.
- Reset (rst==0 at a clock edge): state=REQ, pc=START_ADDR, inst=0, fault_pc=0, instret=0. halted, fault, inst_valid and imem_req_valid are 0 during the reset cycle. Reset applies from any state, including mid-WAIT.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready, go to WAIT next cycle.
  - The request must stay stable while not ready.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid & imem_rsp_err: go to FAULT, fault_pc<=pc.
  - On imem_rsp_valid & ~imem_rsp_err: inst<=imem_rsp_data, go to ISSUE.
  - Response accepted in the same cycle as the request handshake at the earliest next cycle, i.e. minimum REQ→ISSUE = 2 cycles.
- ISSUE:
  - inst_valid=1, inst_pc=pc.
  - On inst_ready, instret<=instret+1 (wraps mod 2^32), then priority:
    - halt → HALT (pc unchanged);
    - else redirect_valid & misaligned & CHECK_ALIGN → FAULT, fault_pc<=redirect_pc;
    - else redirect_valid → pc<=redirect_pc (low bits cleared if CHECK_ALIGN=0), go to REQ;
    - else pc<=pc+4 (32-bit wrap, 32'hFFFFFFFC→0), go to REQ.
  - Without inst_ready, hold everything.
- HALT: halted=1, no requests, inst_valid=0. Sticky until reset.
- FAULT: fault=1, no requests, inst_valid=0. Sticky until reset. instret is not incremented for a faulting redirect's instruction (it did complete) — correction: it is incremented; the redirect fault reports the target, not the branch.
- imem_rsp_valid outside WAIT is ignored (stale response after reset or spurious).
- redirect_valid/halt are ignored unless state==ISSUE & inst_ready.
- All outputs are registered or decoded from state only; no combinational path from inst_ready to imem_req_valid.

Decomposition:
- Package fetch_pkg:
  - state enum (REQ, WAIT, ISSUE, HALT, FAULT), 3-bit encoding;
  - INST_BYTES=4;
  - DEFAULT_START_ADDR=32'h80000000.
- Sub-module next_pc_sel: combinational next-PC/priority/misalign decode (pc, redirect, halt → next_pc, next_state hint, misalign flag).
- FSM, PC, instruction and counter registers stay in fetch_ctrl.

Test Plan:
- Reset release, imem_req_ready=1, responses 1 cycle later with 32'h00000013, inst_ready=1 → imem_req_addr sequence 80000000, 80000004, 80000008; instret=3 after 3 accepts.
- inst_ready held 0 for 5 cycles in ISSUE → inst/inst_pc stable, no new request, instret unchanged.
- Redirect to 32'h80000100 on accept → next imem_req_addr=80000100. Redirect to 32'h80000102 → fault=1, fault_pc=80000102, no further requests.
- imem_rsp_err=1 at pc 80000004 → fault=1, fault_pc=80000004, inst_valid=0 thereafter.
- halt=1 and redirect_valid=1 on the same accept → halted=1, redirect ignored, no request.
- rst=0 during WAIT, then a stale imem_rsp_valid in the first cycle after release → ignored; first request address=START_ADDR; pc=32'hFFFFFFFC sequential step → next address 0.
